// File: rtl/cp0_irq_ctrl_pkg.sv
// Shared CP0 constants: register indices, Status/Cause fields, exception codes, opcodes.
// Pure definitions, no logic state.
package cp0_irq_ctrl_pkg;

    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_STATUS  = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;

    localparam int STATUS_IE  = 0;
    localparam int STATUS_EXL = 1;
    localparam int IRQ_LSB    = 8;
    localparam int EXC_LSB    = 2;

    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_SYS = 5'd8;
    localparam logic [4:0] EXC_BP  = 5'd9;
    localparam logic [4:0] EXC_RI  = 5'd10;
    localparam logic [4:0] EXC_OV  = 5'd12;

    typedef enum logic [2:0] {
        EXP_NONE    = 3'd0,
        EXP_SYSCALL = 3'd1,
        EXP_RI      = 3'd2,
        EXP_OV      = 3'd3,
        EXP_BREAK   = 3'd4
    } exp_src_e;

    localparam logic [10:0] OP_MFC0   = 11'b010000_00000;
    localparam logic [10:0] OP_MTC0   = 11'b010000_00100;
    localparam logic [31:0] INST_ERET = 32'h4200_0018;

    function automatic logic exp_valid(input logic [2:0] src);
        return (src == EXP_SYSCALL) || (src == EXP_RI) ||
               (src == EXP_OV) || (src == EXP_BREAK);
    endfunction

    function automatic logic [4:0] exc_code(input logic [2:0] src);
        case (src)
            EXP_SYSCALL: return EXC_SYS;
            EXP_RI:      return EXC_RI;
            EXP_OV:      return EXC_OV;
            EXP_BREAK:   return EXC_BP;
            default:     return EXC_INT;
        endcase
    endfunction

endpackage

// File: rtl/cp0_irq_ctrl_if.sv
// Pipeline-side bundle between the core and CP0: decode inputs, redirect/mfc0 outputs.
// No handshake: enable qualifies each cycle, outputs are combinational.
interface cp0_irq_ctrl_if #(
    parameter int NUM_IRQ = 6,
    parameter int DATA_W  = 32
);
    logic                enable;
    logic [2:0]          ExpSrc;
    logic [NUM_IRQ-1:0]  irq;
    logic [31:0]         Inst;
    logic [DATA_W-1:0]   PCin;
    logic [DATA_W-1:0]   Din;
    logic                IsEret;
    logic                HasExp;
    logic                ExRegWrite;
    logic                ExpBlock;
    logic [DATA_W-1:0]   PCout;
    logic [DATA_W-1:0]   Dout;

    modport master (
        output enable, ExpSrc, irq, Inst, PCin, Din,
        input  IsEret, HasExp, ExRegWrite, ExpBlock, PCout, Dout
    );

    modport slave (
        input  enable, ExpSrc, irq, Inst, PCin, Din,
        output IsEret, HasExp, ExRegWrite, ExpBlock, PCout, Dout
    );
endinterface

// File: rtl/cp0_irq_ctrl_timer.sv
// Count/Compare timer; Count free-runs, a match sets a sticky pending flag one edge later.
// Writes take effect at the next edge; no stall input, Count ignores pipeline enable.
module cp0_irq_ctrl_timer #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              count_we_i,
    input  logic              compare_we_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] count_o,
    output logic [DATA_W-1:0] compare_o,
    output logic              timer_irq_o
);
    logic [DATA_W-1:0] count_q, count_d;
    logic [DATA_W-1:0] compare_q, compare_d;
    logic              pending_q, pending_d;

    always_comb begin
        count_d   = count_we_i ? wdata_i : count_q + DATA_W'(1);
        compare_d = compare_we_i ? wdata_i : compare_q;
        pending_d = pending_q;
        // Compare write acknowledges; a Count write suppresses a match in the same cycle.
        if (compare_we_i)
            pending_d = 1'b0;
        else if (!count_we_i && (count_q == compare_q))
            pending_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= '0;
            compare_q <= '1;
            pending_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            pending_q <= pending_d;
        end
    end

    assign count_o     = count_q;
    assign compare_o   = compare_q;
    assign timer_irq_o = pending_q;
endmodule

// File: rtl/cp0_irq_ctrl.sv
// CP0 with exception/interrupt entry, eret, mfc0/mtc0; outputs combinational, state next edge.
// No backpressure: enable low stalls all commits except the free-running timer.
module cp0_irq_ctrl
    import cp0_irq_ctrl_pkg::*;
#(
    parameter int                NUM_IRQ      = 6,
    parameter int                DATA_W       = 32,
    parameter logic [DATA_W-1:0] HANDLER_ADDR = 32'h0000_4180
) (
    input  logic          clk,
    input  logic          rst,
    cp0_irq_ctrl_if.slave bus
);
    logic               ie_q, ie_d, exl_q, exl_d;
    logic [NUM_IRQ-1:0] im_q, im_d, ip_q, ip_d, irq_q;
    logic [4:0]         exc_q, exc_d;
    logic [DATA_W-1:0]  epc_q, epc_d;
    logic [DATA_W-1:0]  count, compare, rdata;
    logic               timer_irq;

    logic [4:0] rd;
    logic       sel_ok, is_mfc0, is_mtc0, is_eret, src_vld, int_req;
    logic       has_exp, eret_go, mtc0_we;

    assign rd      = bus.Inst[15:11];
    assign sel_ok  = (bus.Inst[2:0] == 3'd0);
    assign is_mfc0 = (bus.Inst[31:21] == OP_MFC0);
    assign is_mtc0 = (bus.Inst[31:21] == OP_MTC0);
    assign is_eret = (bus.Inst == INST_ERET);
    assign src_vld = exp_valid(bus.ExpSrc);
    assign int_req = ie_q & ~exl_q & |(ip_q & im_q);
    assign has_exp = bus.enable & ~exl_q & (src_vld | int_req);
    assign eret_go = bus.enable & is_eret & ~has_exp;
    assign mtc0_we = bus.enable & is_mtc0 & sel_ok & ~has_exp;

    cp0_irq_ctrl_timer #(.DATA_W(DATA_W)) u_timer (
        .clk          (clk),
        .rst          (rst),
        .count_we_i   (mtc0_we && (rd == REG_COUNT)),
        .compare_we_i (mtc0_we && (rd == REG_COMPARE)),
        .wdata_i      (bus.Din),
        .count_o      (count),
        .compare_o    (compare),
        .timer_irq_o  (timer_irq)
    );

    always_comb begin
        rdata = '0;
        case (rd)
            REG_COUNT:   rdata = count;
            REG_COMPARE: rdata = compare;
            REG_STATUS: begin
                rdata[STATUS_IE]            = ie_q;
                rdata[STATUS_EXL]           = exl_q;
                rdata[IRQ_LSB +: NUM_IRQ]   = im_q;
            end
            REG_CAUSE: begin
                rdata[EXC_LSB +: 5]         = exc_q;
                rdata[IRQ_LSB +: NUM_IRQ]   = ip_q;
            end
            REG_EPC:     rdata = epc_q;
            default:     rdata = '0;
        endcase
    end

    always_comb begin
        ie_d  = ie_q;
        exl_d = exl_q;
        im_d  = im_q;
        exc_d = exc_q;
        epc_d = epc_q;
        ip_d  = irq_q;
        ip_d[NUM_IRQ-1] = irq_q[NUM_IRQ-1] | timer_irq;
        if (has_exp) begin
            epc_d = bus.PCin;
            exl_d = 1'b1;
            exc_d = src_vld ? exc_code(bus.ExpSrc) : EXC_INT;
        end else begin
            if (eret_go)
                exl_d = 1'b0;
            if (mtc0_we) begin
                case (rd)
                    REG_STATUS: begin
                        ie_d  = bus.Din[STATUS_IE];
                        exl_d = bus.Din[STATUS_EXL];
                        im_d  = bus.Din[IRQ_LSB +: NUM_IRQ];
                    end
                    REG_EPC: epc_d = bus.Din;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ie_q  <= 1'b0;
            exl_q <= 1'b0;
            im_q  <= '0;
            exc_q <= EXC_INT;
            ip_q  <= '0;
            irq_q <= '0;
            epc_q <= '0;
        end else begin
            ie_q  <= ie_d;
            exl_q <= exl_d;
            im_q  <= im_d;
            exc_q <= exc_d;
            ip_q  <= ip_d;
            irq_q <= bus.irq;
            epc_q <= epc_d;
        end
    end

    assign bus.HasExp     = has_exp;
    assign bus.IsEret     = eret_go;
    assign bus.ExRegWrite = bus.enable & is_mfc0 & ~has_exp;
    assign bus.ExpBlock   = exl_q;
    assign bus.PCout      = has_exp ? HANDLER_ADDR : (eret_go ? epc_q : '0);
    assign bus.Dout       = (is_mfc0 && sel_ok) ? rdata : '0;
endmodule

// File: tb/tb_cp0_irq_ctrl.sv
// Directed-vector bench: each driven cycle queues its expected outputs, a negedge monitor checks them.
module tb_cp0_irq_ctrl;
    localparam int          NUM_IRQ = 6;
    localparam int          DATA_W  = 32;
    localparam logic [31:0] HV      = 32'h0000_4180;
    localparam logic [31:0] ERET    = 32'h4200_0018;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cp0_irq_ctrl_if #(.NUM_IRQ(NUM_IRQ), .DATA_W(DATA_W)) bus ();

    cp0_irq_ctrl #(.NUM_IRQ(NUM_IRQ), .DATA_W(DATA_W), .HANDLER_ADDR(HV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        int          tag;
        logic        has;
        logic        eret;
        logic        rw;
        logic        blk;
        logic [31:0] pc;
        logic [31:0] dout;
    } exp_t;

    exp_t sb_q[$];
    exp_t exp_e, act_e;
    int   checks = 0;
    int   errors = 0;
    int   tag_n  = 0;

    function automatic logic [31:0] mfc0(input logic [4:0] rd);
        return 32'h4002_0000 | ({27'd0, rd} << 11);
    endfunction

    function automatic logic [31:0] mtc0(input logic [4:0] rd);
        return 32'h4082_0000 | ({27'd0, rd} << 11);
    endfunction

    task automatic cyc(input logic en, input logic [2:0] src, input logic [5:0] iq,
                       input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] din,
                       input logic h, input logic e, input logic w, input logic b,
                       input logic [31:0] epc_o, input logic [31:0] dout_o);
        exp_t x;
        bus.enable = en;
        bus.ExpSrc = src;
        bus.irq    = iq;
        bus.Inst   = inst;
        bus.PCin   = pc;
        bus.Din    = din;
        tag_n++;
        x.tag = tag_n; x.has = h; x.eret = e; x.rw = w; x.blk = b;
        x.pc = epc_o; x.dout = dout_o;
        sb_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            exp_e = sb_q.pop_front();
            act_e = exp_e;
            act_e.has  = bus.HasExp;
            act_e.eret = bus.IsEret;
            act_e.rw   = bus.ExRegWrite;
            act_e.blk  = bus.ExpBlock;
            act_e.pc   = bus.PCout;
            act_e.dout = bus.Dout;
            checks++;
            if (act_e !== exp_e) begin
                errors++;
                $display("FAIL vec%0d has/eret/rw/blk/pc/dout got %b%b%b%b %h %h want %b%b%b%b %h %h",
                         exp_e.tag, act_e.has, act_e.eret, act_e.rw, act_e.blk, act_e.pc, act_e.dout,
                         exp_e.has, exp_e.eret, exp_e.rw, exp_e.blk, exp_e.pc, exp_e.dout);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        bus.enable = 1'b0; bus.ExpSrc = 3'd0; bus.irq = '0;
        bus.Inst = 32'd0; bus.PCin = 32'd0; bus.Din = 32'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        cyc(0, 0, 0, 0,          0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, mfc0(11),   0, 0, 0, 0, 1, 0, 0, 32'hFFFF_FFFF);
        cyc(1, 0, 0, mfc0(12),   0, 0, 0, 0, 1, 0, 0, 0);
        // syscall entry, nested exception blocked, eret
        cyc(1, 1, 0, 0, 32'h0040_0020, 0, 1, 0, 0, 0, HV, 0);
        cyc(1, 0, 0, mfc0(14),   0, 0, 0, 0, 1, 1, 0, 32'h0040_0020);
        cyc(1, 0, 0, mfc0(13),   0, 0, 0, 0, 1, 1, 0, 32'h0000_0020);
        cyc(1, 2, 0, 0, 32'h0040_0030, 0, 0, 0, 0, 1, 0, 0);
        cyc(1, 0, 0, ERET,       0, 0, 0, 1, 0, 1, 32'h0040_0020, 0);
        cyc(0, 0, 0, 0,          0, 0, 0, 0, 0, 0, 0, 0);
        // irq[0] with IE|IM0: entry exactly two cycles after rise
        cyc(1, 0, 0, mtc0(12),   0, 32'h0000_0101, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 32'h0040_0100, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 32'h0040_0100, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 32'h0040_0100, 0, 1, 0, 0, 0, HV, 0);
        cyc(1, 0, 0, mfc0(14),   0, 0, 0, 0, 1, 1, 0, 32'h0040_0100);
        cyc(1, 0, 0, mfc0(13),   0, 0, 0, 0, 1, 1, 0, 32'h0000_0100);
        cyc(1, 0, 0, ERET,       0, 0, 0, 1, 0, 1, 32'h0040_0100, 0);
        cyc(0, 0, 0, 0,          0, 0, 0, 0, 0, 0, 0, 0);
        // IM0 masked: no entry, IP still visible
        cyc(1, 0, 0, mtc0(12),   0, 32'h0000_0001, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            cyc(1, 0, 1, 0, 32'h0040_0180, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, mfc0(13),   0, 0, 0, 0, 1, 0, 0, 32'h0000_0100);
        cyc(0, 0, 0, 0,          0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0,          0, 0, 0, 0, 0, 0, 0, 0);
        // timer: Count=100, Compare=105, IE|IM5
        cyc(1, 0, 0, mtc0(9),    0, 32'd100, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, mfc0(9),    0, 0, 0, 0, 1, 0, 0, 32'd100);
        cyc(1, 0, 0, mtc0(11),   0, 32'd105, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, mtc0(12),   0, 32'h0000_2001, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            cyc(1, 0, 0, 0, 32'h0040_0200, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 32'h0040_0200, 0, 1, 0, 0, 0, HV, 0);
        cyc(1, 0, 0, mfc0(13),   0, 0, 0, 0, 1, 1, 0, 32'h0000_2000);
        cyc(1, 0, 0, mtc0(11),   0, 32'd0, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0,          0, 0, 0, 0, 0, 1, 0, 0);
        cyc(1, 0, 0, mfc0(13),   0, 0, 0, 0, 1, 1, 0, 32'h0000_0000);
        cyc(1, 0, 0, ERET,       0, 0, 0, 1, 0, 1, 32'h0040_0200, 0);
        cyc(0, 0, 0, 0,          0, 0, 0, 0, 0, 0, 0, 0);
        // overflow discards a same-cycle mtc0 EPC
        cyc(1, 3, 0, mtc0(14), 32'h0040_0300, 32'hDEAD_BEEF, 1, 0, 0, 0, HV, 0);
        cyc(1, 0, 0, mfc0(14),   0, 0, 0, 0, 1, 1, 0, 32'h0040_0300);
        cyc(1, 0, 0, mfc0(13),   0, 0, 0, 0, 1, 1, 0, 32'h0000_0030);
        cyc(1, 0, 0, ERET,       0, 0, 0, 1, 0, 1, 32'h0040_0300, 0);
        cyc(0, 0, 0, 0,          0, 0, 0, 0, 0, 0, 0, 0);
        // irq and syscall together: syscall wins
        cyc(1, 0, 0, mtc0(12),   0, 32'h0000_0101, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 32'h0040_03F0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 0, 32'h0040_0400, 0, 1, 0, 0, 0, HV, 0);
        cyc(1, 0, 0, mfc0(13),   0, 0, 0, 0, 1, 1, 0, 32'h0000_0120);
        cyc(1, 0, 0, mfc0(14),   0, 0, 0, 0, 1, 1, 0, 32'h0040_0400);
        cyc(1, 0, 0, ERET,       0, 0, 0, 1, 0, 1, 32'h0040_0400, 0);
        cyc(0, 0, 0, 0,          0, 0, 0, 0, 0, 0, 0, 0);
        // eret with EXL clear still redirects; sel!=0 and unmapped rd read 0
        cyc(1, 0, 0, ERET,       0, 0, 0, 1, 0, 0, 32'h0040_0400, 0);
        cyc(1, 0, 0, mfc0(12) | 32'd1, 0, 0, 0, 0, 1, 0, 0, 0);
        cyc(1, 0, 0, mfc0(5),    0, 0, 0, 0, 1, 0, 0, 0);
        cyc(1, 0, 0, mfc0(12),   0, 0, 0, 0, 1, 0, 0, 32'h0000_0101);
        cyc(0, 0, 0, 0,          0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 10 && sb_q.size() != 0; i++)
            @(posedge clk);
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d want 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cp0_irq_ctrl.md
Name: cp0_irq_ctrl

Overview:
Parametrised coprocessor-0 for the MIPS core that adds a vectored interrupt controller and timer to the existing syscall/EPC/eret handling. It holds Status, Cause, EPC, Count and Compare, and arbitrates synchronous exceptions against NUM_IRQ masked interrupt lines. It redirects the PC on exception entry or eret, and serves mfc0/mtc0 to the register-file stage.

Parameters:
NUM_IRQ, 6, external interrupt lines (1..7); line NUM_IRQ-1 is OR'd with the internal timer interrupt.
DATA_W, 32, datapath width.
HANDLER_ADDR, 32'h0000_4180, exception/interrupt vector driven on pc_out at entry.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
enable  in  1  instruction valid this cycle (low = stall/bubble); gates all commits.
ExpSrc  in  3  synchronous exception source: 000 none, 001 syscall, 010 reserved inst, 011 overflow, 100 break, others reserved (treated as none).
irq  in  NUM_IRQ  level-sensitive external interrupt requests.
Inst  in  32  current instruction (mfc0/mtc0/eret decode).
PCin  in  DATA_W  PC of current instruction.
Din  in  DATA_W  mtc0 write data (rt).
IsEret  out  1  eret committing this cycle.
HasExp  out  1  exception/interrupt taken this cycle.
ExRegWrite  out  1  mfc0 in flight: write Dout to GPR rt.
ExpBlock  out  1  Status.EXL, i.e. handler active; nested entry blocked.
PCout  out  DATA_W  redirect target.
Dout  out  DATA_W  mfc0 read data.

Behaviour:
- Decode: mfc0 = Inst[31:21]==010000_00000; mtc0 = Inst[31:21]==010000_00100; eret = Inst==32'h4200_0018; rd = Inst[15:11]; sel Inst[2:0] must be 0, else mfc0 returns 0 and mtc0 is ignored.
- Registers: Count rd9, Compare rd11, Status rd12 (bit0 IE, bit1 EXL, bits[8+NUM_IRQ-1:8] IM, rest read 0), Cause rd13 (bits[6:2] ExcCode, bits[8+NUM_IRQ-1:8] IP, read-only to mtc0), EPC rd14. Other rd read 0 and ignore writes.
- Reset (rst=1 at edge): Status=0, Cause=0, EPC=0, Count=0, Compare=32'hFFFF_FFFF, timer pending=0, irq sync stage=0. Outputs then: HasExp=0, IsEret=0, ExRegWrite=0, ExpBlock=0, Dout=0, PCout=0. Reset mid-handler clears EXL.
- IP: irq registered once per cycle (1-cycle latency into Cause.IP); IP[NUM_IRQ-1] = irq_q[NUM_IRQ-1] | timer_pending.
- Timer: Count += 1 every cycle (independent of enable); wraps FFFF_FFFF->0. Count==Compare sets timer_pending (sticky) next edge. mtc0 to Compare clears timer_pending. mtc0 to Count in a match cycle: the write wins and no pending is set.
- Interrupt request: int_req = IE & ~EXL & |(IP & IM).
- Entry (combinational HasExp): enable & ~EXL & (ExpSrc valid | int_req). Sync exception has priority over interrupt. At edge: EPC<=PCin, EXL<=1, ExcCode<= 8/10/12/9 for syscall/RI/Ov/Bp, 0 for interrupt. PCout=HANDLER_ADDR in the same cycle. ExpSrc valid while EXL=1: not taken, no state change.
- eret: IsEret = enable & eret & ~HasExp; PCout=EPC combinationally; EXL<=0 at edge. eret while EXL=0 still redirects to EPC.
- mfc0: ExRegWrite = enable & mfc0 & ~HasExp; Dout = selected register (current, pre-edge value).
- mtc0: commits at edge when enable & ~HasExp. Exception in the same cycle discards the write.
- PCout = 0 when neither HasExp nor IsEret. Dout = 0 when not mfc0.
- Latency: all outputs combinational from current state and inputs; all state changes visible next cycle.

Decomposition:
- cp0_pkg: register indices (9/11/12/13/14), Status/Cause bit positions, ExcCode constants, ExpSrc encodings, mfc0/mtc0/eret opcode fields.
- Sub-module cp0_timer: Count/Compare/timer_pending, with write strobes in and timer_irq out.

Test Plan:
- rst held 2 cycles -> all outputs 0; mfc0 rd11 returns FFFF_FFFF; mfc0 rd12 returns 0.
- ExpSrc=001, PCin=0040_0020, enable=1 -> HasExp=1, PCout=HANDLER_ADDR same cycle; next cycle mfc0 rd14 gives 0040_0020, rd13[6:2]=8, ExpBlock=1; second ExpSrc=010 -> HasExp=0.
- eret after that entry -> IsEret=1, PCout=0040_0020; next cycle ExpBlock=0.
- mtc0 Status=0000_0101 (IE, IM0), raise irq[0], PCin=0040_0100 -> HasExp asserted exactly 2 cycles after irq rises (sync stage + IP); EPC=0040_0100, ExcCode=0. Same with IM0=0 -> no entry.
- mtc0 Compare=Count+5, Status enables IM[NUM_IRQ-1] -> interrupt ~6 cycles later; mtc0 Compare clears Cause.IP[NUM_IRQ-1].
- ExpSrc=011 with mtc0 EPC in the same cycle -> write discarded, EPC=PCin; simultaneous irq and ExpSrc=001 -> ExcCode=8.
